// File: rtl/pwm_channel_bank_if.sv
// Configuration port of the PWM channel bank: shadow-register writes and the
// commit request/acknowledge pair.
interface pwm_channel_bank_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned ADDR_W = 4;

    logic              cfg_write;
    logic [ADDR_W-1:0] cfg_addr;
    logic [WIDTH-1:0]  cfg_data;
    logic              cfg_commit;
    logic              commit_pending;

    modport master (
        output cfg_write,
        output cfg_addr,
        output cfg_data,
        output cfg_commit,
        input  commit_pending
    );

    modport slave (
        input  cfg_write,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_commit,
        output commit_pending
    );
endinterface

// File: rtl/pwm_channel_bank.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty compare,
// double-buffered period/duty registers that only take effect at a cycle boundary.
module pwm_channel_bank #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned INITIAL_PERIOD = 100,
    parameter int unsigned INITIAL_DUTY   = 50
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    pwm_channel_bank_if.slave   cfg,
    output logic [CHANNELS-1:0] out,
    output logic                cycle_end,
    output logic [WIDTH-1:0]    count
);
    localparam int unsigned     ADDR_W       = 4;
    localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(INITIAL_PERIOD);
    localparam logic [WIDTH-1:0] RESET_DUTY   = WIDTH'(INITIAL_DUTY);

    logic [WIDTH-1:0]                count_q;
    logic [WIDTH-1:0]                period_active;
    logic [WIDTH-1:0]                period_shadow;
    logic [WIDTH-1:0]                period_shadow_nxt;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_active;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_shadow;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_shadow_nxt;
    logic                            pending_q;
    logic                            commit_req_c;
    logic                            apply_c;

    assign count              = count_q;
    assign cfg.commit_pending = pending_q;

    // Terminal count; never asserted while held, so a held bank flushes commits via ~enable.
    assign cycle_end    = enable & (count_q >= period_active);
    assign commit_req_c = pending_q | cfg.cfg_commit;
    assign apply_c      = commit_req_c & (cycle_end | ~enable);

    // Shadow write decode; the result also feeds the active load so a same-cycle write is included.
    always_comb begin
        period_shadow_nxt = period_shadow;
        duty_shadow_nxt   = duty_shadow;
        if (cfg.cfg_write) begin
            if (cfg.cfg_addr == '0) begin
                period_shadow_nxt = cfg.cfg_data;
            end
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (cfg.cfg_addr == ADDR_W'(k + 1)) begin
                    duty_shadow_nxt[k] = cfg.cfg_data;
                end
            end
        end
    end

    // Zero-latency compare outputs, forced low while held.
    always_comb begin
        out = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            out[k] = enable & (count_q < duty_active[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q       <= '0;
            period_active <= RESET_PERIOD;
            period_shadow <= RESET_PERIOD;
            duty_active   <= {CHANNELS{RESET_DUTY}};
            duty_shadow   <= {CHANNELS{RESET_DUTY}};
            pending_q     <= 1'b0;
        end else begin
            period_shadow <= period_shadow_nxt;
            duty_shadow   <= duty_shadow_nxt;
            if (apply_c) begin
                period_active <= period_shadow_nxt;
                duty_active   <= duty_shadow_nxt;
            end
            pending_q <= commit_req_c & ~apply_c;
            // Active period only changes at a wrap or while held, so count never overshoots it.
            if (cycle_end | ~enable) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pwm_channel_bank.sv
// Self-checking bench for pwm_channel_bank: scenario tasks plus randomized traffic,
// compared against a transaction-level model of the counter, shadows and commit rule.
module tb_pwm_channel_bank;
    localparam int unsigned W  = 32;
    localparam int unsigned CH = 4;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [CH-1:0] out;
    logic          cycle_end;
    logic [W-1:0]  count;

    pwm_channel_bank_if #(.WIDTH(W)) cfg ();

    pwm_channel_bank #(
        .WIDTH(W), .CHANNELS(CH), .INITIAL_PERIOD(100), .INITIAL_DUTY(50)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .cfg(cfg),
        .out(out), .cycle_end(cycle_end), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_err;

    // Reference model state
    int unsigned m_count;
    int unsigned m_period_a;
    int unsigned m_period_s;
    int unsigned m_duty_a [CH];
    int unsigned m_duty_s [CH];
    bit          m_pending;

    function automatic logic [W+CH+1:0] model_vec();
        logic [CH-1:0] o;
        logic          ce;
        ce = enable && (m_count >= m_period_a);
        for (int k = 0; k < CH; k++) o[k] = enable && (m_count < m_duty_a[k]);
        return {W'(m_count), o, ce, m_pending};
    endfunction

    task automatic drive(input bit en, input bit wr, input int unsigned addr,
                         input int unsigned data, input bit commit);
        enable         = en;
        cfg.cfg_write  = wr;
        cfg.cfg_addr   = 4'(addr);
        cfg.cfg_data   = W'(data);
        cfg.cfg_commit = commit;
    endtask

    // Advance one clock, updating the model with the inputs held during that cycle.
    task automatic step();
        bit ce;
        bit req;
        @(posedge clock);
        if (reset) begin
            m_count = 0; m_period_a = 100; m_period_s = 100; m_pending = 0;
            for (int k = 0; k < CH; k++) begin m_duty_a[k] = 50; m_duty_s[k] = 50; end
        end else begin
            ce = enable && (m_count >= m_period_a);
            if (cfg.cfg_write) begin
                if (cfg.cfg_addr == 0) m_period_s = cfg.cfg_data;
                else if (cfg.cfg_addr <= CH) m_duty_s[cfg.cfg_addr - 1] = cfg.cfg_data;
            end
            req = m_pending || cfg.cfg_commit;
            if (req && (ce || !enable)) begin
                m_period_a = m_period_s;
                m_duty_a   = m_duty_s;
                m_pending  = 0;
            end else begin
                m_pending = req;
            end
            m_count = (!enable || ce) ? 0 : m_count + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1, 0, $urandom, 1);
        step();
        reset = 1'b0;
        drive(1, 0, 0, 0, 0);
        #1; n_cmp++;
        if ({count, cfg.commit_pending, cycle_end, out} !== {32'd0, 1'b0, 1'b0, 4'hf}) begin
            n_err++;
            $display("FAIL reset_state: got count=%0d pend=%b ce=%b out=%b, expected 0 0 0 1111",
                     count, cfg.commit_pending, cycle_end, out);
        end
        n_cmp++;
        if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
            n_err++;
            $display("FAIL reset_model: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
        end
        step();
    endtask

    task automatic test_default_waveform();
        int hi0, ce_n, ce_bad;
        hi0 = 0; ce_n = 0; ce_bad = 0;
        do_reset();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 202; i++) begin
            #1; n_cmp++;
            if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                n_err++;
                $display("FAIL default_model: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
            end
            hi0 += int'(out[0]);
            if (cycle_end) begin ce_n++; if (count != 100) ce_bad++; end
            step();
        end
        n_cmp++;
        if (hi0 != 100 || ce_n != 2 || ce_bad != 0) begin
            n_err++;
            $display("FAIL default_waveform: got high=%0d ce=%0d ce_off=%0d, expected 100 2 0", hi0, ce_n, ce_bad);
        end
    endtask

    task automatic test_commit_at_boundary();
        int pend_bad, hi0, hi123, ce_n;
        pend_bad = 0; hi0 = 0; hi123 = 0; ce_n = 0;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            if (i == 20)      drive(1, 1, 0, 9, 0);
            else if (i == 21) drive(1, 1, 1, 3, 0);
            else if (i == 22) drive(1, 0, 0, 0, 1);
            else              drive(1, 0, 0, 0, 0);
            #1; n_cmp++;
            if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                n_err++;
                $display("FAIL commit_setup: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
            end
            step();
        end
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 78 + 10; i++) begin
            #1; n_cmp++;
            if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                n_err++;
                $display("FAIL commit_model: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
            end
            if (i < 78) begin
                if (!cfg.commit_pending) pend_bad++;
            end else begin
                hi0 += int'(out[0]);
                if (out[3:1] == 3'b111) hi123++;
                ce_n += int'(cycle_end);
            end
            step();
        end
        n_cmp++;
        if (pend_bad != 0 || hi0 != 3 || hi123 != 10 || ce_n != 1 || count != 0) begin
            n_err++;
            $display("FAIL commit_boundary: got pend_gaps=%0d high0=%0d high123=%0d ce=%0d count=%0d, expected 0 3 10 1 0",
                     pend_bad, hi0, hi123, ce_n, count);
        end
    endtask

    task automatic test_extreme_duty();
        int bad;
        do_reset();
        drive(1, 1, 3, 0, 0);   step();
        drive(1, 1, 4, 200, 1); step();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 300 && cfg.commit_pending; i++) step();
        n_cmp++;
        if (cfg.commit_pending !== 1'b0) begin
            n_err++;
            $display("FAIL duty_commit_timeout: got pending=%b, expected 0", cfg.commit_pending);
        end
        bad = 0;
        for (int i = 0; i < 101; i++) begin
            #1; n_cmp++;
            if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                n_err++;
                $display("FAIL extreme_model: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
            end
            if (out[2] !== 1'b0 || out[3] !== 1'b1) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL extreme_duty: got %0d bad cycles, expected 0", bad);
        end
        drive(1, 1, 0, 0, 1); step();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 300 && cfg.commit_pending; i++) step();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cycle_end !== 1'b1 || count !== 0 || cfg.commit_pending !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL period_zero: got %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_same_cycle_commit();
        int hi1;
        bit pend_seen;
        hi1 = 0; pend_seen = 0;
        do_reset();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step();
        drive(1, 1, 2, 7, 1);
        #1; n_cmp++;
        if ({count, cycle_end, cfg.commit_pending} !== {32'd100, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL same_cycle_setup: got count=%0d ce=%b pend=%b, expected 100 1 0",
                     count, cycle_end, cfg.commit_pending);
        end
        step();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 101; i++) begin
            #1; n_cmp++;
            if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                n_err++;
                $display("FAIL same_cycle_model: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
            end
            hi1 += int'(out[1]);
            pend_seen |= cfg.commit_pending;
            step();
        end
        n_cmp++;
        if (hi1 != 7 || pend_seen) begin
            n_err++;
            $display("FAIL same_cycle_commit: got high1=%0d pend_seen=%b, expected 7 0", hi1, pend_seen);
        end
    endtask

    task automatic test_disable_commit();
        int hi0, ce_n;
        do_reset();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();
        drive(1, 1, 0, 30, 0); step();
        drive(1, 0, 0, 0, 1);  step();
        drive(0, 0, 0, 0, 0);
        #1; n_cmp++;
        if ({out, cycle_end, cfg.commit_pending} !== {4'h0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL disable_outputs: got out=%b ce=%b pend=%b, expected 0000 0 1",
                     out, cycle_end, cfg.commit_pending);
        end
        step();
        #1; n_cmp++;
        if ({count, cfg.commit_pending} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL disable_flush: got count=%0d pend=%b, expected 0 0", count, cfg.commit_pending);
        end
        step();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                drive(1, 1, 5, 3, 0);  step();
                drive(1, 1, 15, 3, 0); step();
                drive(1, 0, 0, 0, 1);  step();
                drive(1, 0, 0, 0, 0);
                for (int i = 0; i < 200 && cfg.commit_pending; i++) step();
            end
            drive(1, 0, 0, 0, 0);
            hi0 = 0; ce_n = 0;
            for (int i = 0; i < 31; i++) begin
                #1; n_cmp++;
                if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                    n_err++;
                    $display("FAIL disable_model: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
                end
                hi0 += int'(out[0]);
                ce_n += int'(cycle_end);
                step();
            end
            n_cmp++;
            if (hi0 != 31 || ce_n != 1) begin
                n_err++;
                $display("FAIL disable_period pass %0d: got high0=%0d ce=%0d, expected 31 1", pass, hi0, ce_n);
            end
        end
    endtask

    task automatic test_reset_mid_cycle();
        int hi0, ce_n, ce_off;
        do_reset();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 35; i++) step();
        drive(1, 1, 0, 9, 0); step();
        drive(1, 0, 0, 0, 1); step();
        drive(1, 0, 0, 0, 0);
        #1; n_cmp++;
        if ({count, cfg.commit_pending} !== {32'd37, 1'b1}) begin
            n_err++;
            $display("FAIL midreset_setup: got count=%0d pend=%b, expected 37 1", count, cfg.commit_pending);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1; n_cmp++;
        if ({count, cfg.commit_pending} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_state: got count=%0d pend=%b, expected 0 0", count, cfg.commit_pending);
        end
        drive(1, 0, 0, 0, 1); step();
        drive(1, 0, 0, 0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            hi0 = 0; ce_n = 0; ce_off = 0;
            for (int i = 0; i < 101; i++) begin
                #1; n_cmp++;
                if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                    n_err++;
                    $display("FAIL midreset_model: got %h expected %h", {count, out, cycle_end, cfg.commit_pending}, model_vec());
                end
                hi0 += int'(out[0]);
                if (cycle_end) begin ce_n++; if (count != 100) ce_off++; end
                step();
            end
            n_cmp++;
            if (hi0 != 50 || ce_n != 1 || ce_off != 0) begin
                n_err++;
                $display("FAIL midreset_shadow pass %0d: got high0=%0d ce=%0d ce_off=%0d, expected 50 1 0",
                         pass, hi0, ce_n, ce_off);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 6),
                  $urandom_range(0, 40), $urandom_range(0, 7) == 0);
            #1; n_cmp++;
            if ({count, out, cycle_end, cfg.commit_pending} !== model_vec()) begin
                n_err++;
                $display("FAIL random cycle %0d: got %h expected %h", i,
                         {count, out, cycle_end, cfg.commit_pending}, model_vec());
            end
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        test_reset();
        test_default_waveform();
        test_commit_at_boundary();
        test_extreme_duty();
        test_same_cycle_commit();
        test_disable_commit();
        test_reset_mid_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_channel_bank.md
Name: pwm_channel_bank

Overview:
- Multi-channel PWM generator. All channels share one period counter. Each channel has its own duty compare value.
- Period and duty values are double-buffered. New values reach the outputs only at a cycle boundary, so a period or duty change never produces a glitch.
- Sits between the control/UART register layer and the gate-drive outputs. Successor to the single-channel fixed-50%-duty period generator.

Parameters:
- WIDTH, 32, width of the counter, period and duty values.
- CHANNELS, 4, number of PWM outputs (1..15).
- INITIAL_PERIOD, 100, period value (active and shadow) after reset.
- INITIAL_DUTY, 50, duty value of every channel (active and shadow) after reset.

Ports:
- clock  in  1  system clock, all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run/hold control for the counter.
- cfg_write  in  1  write cfg_data into the shadow register at cfg_addr.
- cfg_addr  in  4  0 = period shadow; k (1..CHANNELS) = duty shadow of channel k-1.
- cfg_data  in  WIDTH  write data.
- cfg_commit  in  1  request transfer of all shadow registers to the active registers.
- commit_pending  out  1  a commit is requested but not yet applied.
- out  out  CHANNELS  PWM outputs.
- cycle_end  out  1  counter is at its terminal value this cycle.
- count  out  WIDTH  current counter value.

Behaviour:
- Reset:
  - count=0; active and shadow period=INITIAL_PERIOD; all active and shadow duties=INITIAL_DUTY; commit_pending=0.
  - Reset overrides every other input in the same cycle.
- Counter:
  - When enable=1: count runs 0..period_active inclusive, so one cycle is period_active+1 clocks.
  - cycle_end = enable & (count >= period_active), combinational from registered state.
  - On a clock edge with cycle_end=1, count goes to 0; otherwise count+1.
  - Arithmetic is WIDTH-bit unsigned. count never exceeds period_active.
- period_active=0: count stays at 0 and cycle_end=1 every clock while enabled.
- Outputs:
  - out[k] = enable & (count < duty_active[k]), combinational, zero latency.
  - duty 0 gives a constant 0. duty > period_active gives a constant 1.
- Config writes:
  - A write updates the shadow register only. A write to an address > CHANNELS is ignored.
  - A write never changes the active registers directly.
- Commit:
  - Effective request = commit_pending | cfg_commit.
  - Apply condition: effective request, and either cycle_end=1 or enable=0.
  - When the apply condition holds, at that clock edge all active registers load from the shadows. A cfg_write in the same cycle bypasses into the loaded value. commit_pending is then 0.
  - Otherwise commit_pending = effective request.
  - cfg_commit while already pending has no additional effect. Values written after the commit request but before the boundary are included.
- Disabled (enable=0):
  - count is forced to 0 on the next edge; out=0; cycle_end=0.
  - Pending commits apply on the next edge.
- Re-enable: the first cycle starts at count=0 and uses the active values.
- Reset mid-cycle: immediate return to the reset state; the pending commit is dropped.
- Implementation note: active period and duties never change except at a cycle boundary or while disabled. Count therefore never needs to wrap past a shrunken period.

Test Plan:
- Reset with defaults, enable=1, CHANNELS=4 → each out[k] high for 50 clocks, low for 51; cycle_end pulses every 101 clocks while count=100.
- Write addr0=9 and addr1=3 at count=20, then commit → commit_pending=1 until the edge at count=100; next cycle is 10 clocks long and out[0] is high for 3 of them; out[1..3] are high for 10 of 10 (duty 50 > period 9).
- Duty 0 on ch2, duty 200 with period 100 on ch3 → out[2] constantly 0, out[3] constantly 1; period 0 → cycle_end constantly 1, count stays 0.
- cfg_write addr2=7 together with cfg_commit in the cycle where cycle_end=1 → duty 7 is active from count=0 of the next cycle; commit_pending never rises.
- enable=0 with commit pending → count=0, out=0 after one edge, active registers updated, pending cleared; write to addr 5 with CHANNELS=4 → no register changes.
- reset asserted at count=37 with a commit pending → next cycle count=0, period=100, commit_pending=0, shadow registers restored.
